// File: rtl/note_scheduler.sv
// Falling-note table for a three-lane playfield: advances, judges and
// spawns notes once per frame during vblank, and answers pixel queries.
module note_scheduler #(
    parameter int SLOTS   = 8,
    parameter int SPEED   = 4,
    parameter int NOTE_H  = 16,
    parameter int HIT_Y   = 380,
    parameter int HIT_WIN = 12,
    parameter int MISS_Y  = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [1:0]  note_lane,
    input  logic [15:0] note_frame,
    input  logic [2:0]  btn,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic        pix_note,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic [15:0] score,
    output logic [7:0]  streak,
    output logic [15:0] frame_cnt
);

    // JUDGE must last at least three cycles so every lane gets a turn
    localparam int JLEN = (SLOTS < 3) ? 3 : SLOTS;
    localparam int IW   = $clog2(JLEN);

    typedef enum logic [1:0] {IDLE, ADVANCE, JUDGE, SPAWN} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [1:0]       lane_q [SLOTS];
    logic [1:0]       lane_d [SLOTS];
    logic [9:0]       y_q [SLOTS];
    logic [9:0]       y_d [SLOTS];
    logic [15:0]      score_q, score_d;
    logic [15:0]      frame_q, frame_d;
    logic [7:0]       streak_q, streak_d;
    logic [2:0]       pend_q, pend_d, snap_q, snap_d, prev_q;
    logic             hit_q, hit_d, miss_q, miss_d, pix_q, pix_d;

    logic [2:0]       rise;
    logic [10:0]      adv_y;
    logic [IW-1:0]    free_idx, hit_idx;
    logic             hit_found, judge_sel, ready, accept;
    int unsigned      nfree;

    function automatic logic in_lane(input logic [1:0] l, input logic [9:0] x);
        case (l)
            2'd0:    in_lane = (x >= 10'd4) && (x <= 10'd211);
            2'd1:    in_lane = (x >= 10'd217) && (x <= 10'd423);
            2'd2:    in_lane = (x >= 10'd428) && (x <= 10'd635);
            default: in_lane = 1'b0;
        endcase
    endfunction

    function automatic logic in_win(input logic [9:0] y);
        logic [10:0] y11;
        y11 = {1'b0, y};
        in_win = (y11 + 11'(HIT_WIN) >= 11'(HIT_Y)) &&
                 (y11 <= 11'(HIT_Y + HIT_WIN));
    endfunction

    function automatic logic in_rows(input logic [9:0] y, input logic [9:0] py);
        in_rows = ({1'b0, py} >= {1'b0, y}) &&
                  ({1'b0, py} < {1'b0, y} + 11'(NOTE_H));
    endfunction

    assign rise      = btn & ~prev_q;
    assign adv_y     = {1'b0, y_q[idx_q]} + 11'(SPEED);
    assign ready     = (state_q == SPAWN) && (nfree != 0) && (frame_q >= note_frame);
    assign accept    = ready && note_valid;
    assign judge_sel = (idx_q < IW'(3)) && |(snap_q & (3'b001 << idx_q[1:0]));

    // Descending scans so the lowest matching index wins
    always_comb begin
        nfree     = 0;
        free_idx  = '0;
        hit_found = 1'b0;
        hit_idx   = '0;
        pix_d     = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                nfree    = nfree + 1;
                free_idx = IW'(i);
            end
            if (valid_q[i] && lane_q[i] == idx_q[1:0] && in_win(y_q[i])) begin
                hit_found = 1'b1;
                hit_idx   = IW'(i);
            end
            if (valid_q[i] && in_lane(lane_q[i], pix_x) && in_rows(y_q[i], pix_y))
                pix_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        lane_d   = lane_q;
        y_d      = y_q;
        score_d  = score_q;
        streak_d = streak_q;
        frame_d  = frame_q;
        pend_d   = pend_q | rise;
        snap_d   = snap_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    frame_d = frame_q + 16'd1;
                    idx_d   = '0;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (valid_q[idx_q]) begin
                    if (adv_y >= 11'(MISS_Y)) begin
                        valid_d[idx_q] = 1'b0;
                        miss_d         = 1'b1;
                        streak_d       = '0;
                    end else begin
                        y_d[idx_q] = adv_y[9:0];
                    end
                end
                if (idx_q == IW'(SLOTS - 1)) begin
                    idx_d   = '0;
                    snap_d  = pend_q | rise;
                    pend_d  = '0;
                    state_d = JUDGE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            JUDGE: begin
                if (judge_sel) begin
                    if (hit_found) begin
                        valid_d[hit_idx] = 1'b0;
                        hit_d            = 1'b1;
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                        if (streak_q != 8'hFF) streak_d = streak_q + 8'd1;
                    end else begin
                        miss_d   = 1'b1;
                        streak_d = '0;
                    end
                end
                if (idx_q == IW'(JLEN - 1)) state_d = SPAWN;
                else idx_d = idx_q + 1'b1;
            end
            SPAWN: begin
                state_d = IDLE;
                if (accept) begin
                    if (note_lane != 2'd3) begin
                        valid_d[free_idx] = 1'b1;
                        lane_d[free_idx]  = note_lane;
                        y_d[free_idx]     = '0;
                        if (nfree > 1) state_d = SPAWN;
                    end else begin
                        state_d = SPAWN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            valid_q  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                lane_q[i] <= '0;
                y_q[i]    <= '0;
            end
            score_q  <= '0;
            streak_q <= '0;
            frame_q  <= '0;
            pend_q   <= '0;
            snap_q   <= '0;
            prev_q   <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            lane_q   <= lane_d;
            y_q      <= y_d;
            score_q  <= score_d;
            streak_q <= streak_d;
            frame_q  <= frame_d;
            pend_q   <= pend_d;
            snap_q   <= snap_d;
            prev_q   <= btn;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            pix_q    <= pix_d;
        end
    end

    assign note_ready = ready;
    assign pix_note   = pix_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign streak     = streak_q;
    assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed scenarios plus random frames
// checked against a per-frame behavioural model of the note table.
module tb_note_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        note_valid = 1'b0;
    logic [1:0]  note_lane = 2'd0;
    logic [15:0] note_frame = 16'd0;
    logic [2:0]  btn = 3'd0;
    logic [9:0]  pix_x = 10'd0;
    logic [9:0]  pix_y = 10'd0;
    logic        note_ready, pix_note, hit_pulse, miss_pulse;
    logic [15:0] score, frame_cnt;
    logic [7:0]  streak;

    note_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_lane  (note_lane),
        .note_frame (note_frame),
        .btn        (btn),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_note   (pix_note),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .streak     (streak),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lane;
        int fr;
    } offer_t;

    offer_t      offq[$];
    int          total = 0;
    int          bad = 0;
    bit          m_v[8];
    int          m_lane[8];
    int          m_y[8];
    int          m_score, m_streak, m_frame;
    bit [2:0]    m_pend;
    int          pcyc[$];
    logic [31:0] last_seq;
    int          last_acc;
    int          lo[3] = '{4, 217, 428};
    int          hi[3] = '{211, 423, 635};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void offer(input int l, input int f);
        offer_t o;
        o.lane = l;
        o.fr   = f;
        offq.push_back(o);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_v[i]    = 1'b0;
            m_lane[i] = 0;
            m_y[i]    = 0;
        end
        m_score  = 0;
        m_streak = 0;
        m_frame  = 0;
        m_pend   = 3'b000;
        offq.delete();
    endfunction

    function automatic bit model_pix(input int x, input int y);
        bit r;
        r = 1'b0;
        for (int i = 0; i < 8; i++)
            if (m_v[i] && x >= lo[m_lane[i]] && x <= hi[m_lane[i]] &&
                y >= m_y[i] && y < m_y[i] + 16)
                r = 1'b1;
        return r;
    endfunction

    // One whole vblank: fall, expire, judge the presses, then spawn
    function automatic void model_frame(output logic [31:0] seq, output int k);
        bit [2:0] snap;
        int f, nf;
        seq = '0;
        k = 0;
        m_frame = (m_frame + 1) % 65536;
        for (int i = 0; i < 8; i++) begin
            if (m_v[i]) begin
                m_y[i] += 4;
                if (m_y[i] >= 480) begin
                    m_v[i] = 1'b0;
                    seq = {seq[29:0], 2'b10};
                    m_streak = 0;
                end
            end
        end
        snap = m_pend;
        m_pend = 3'b000;
        for (int l = 0; l < 3; l++) begin
            if (snap[l]) begin
                f = -1;
                for (int i = 7; i >= 0; i--)
                    if (m_v[i] && m_lane[i] == l && m_y[i] - 380 <= 12 && 380 - m_y[i] <= 12)
                        f = i;
                if (f >= 0) begin
                    m_v[f] = 1'b0;
                    seq = {seq[29:0], 2'b01};
                    if (m_score < 65535) m_score++;
                    if (m_streak < 255) m_streak++;
                end else begin
                    seq = {seq[29:0], 2'b10};
                    m_streak = 0;
                end
            end
        end
        while (k < offq.size()) begin
            nf = -1;
            for (int i = 7; i >= 0; i--)
                if (!m_v[i]) nf = i;
            if (nf < 0 || offq[k].fr > m_frame) break;
            if (offq[k].lane != 3) begin
                m_v[nf]    = 1'b1;
                m_lane[nf] = offq[k].lane;
                m_y[nf]    = 0;
            end
            k++;
        end
        for (int i = 0; i < k; i++) void'(offq.pop_front());
    endfunction

    task automatic run_frame(input bit stray, output logic [31:0] seq, output int acc);
        seq = '0;
        acc = 0;
        pcyc.delete();
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (hit_pulse || miss_pulse) begin
                seq = {seq[29:0], miss_pulse, hit_pulse};
                pcyc.push_back(c);
            end
            frame_tick = (c == 0) || (stray && c == 5);
            note_valid = acc < offq.size();
            if (note_valid) begin
                note_lane  = 2'(offq[acc].lane);
                note_frame = 16'(offq[acc].fr);
            end
            #1;
            if (note_valid && note_ready) acc++;
        end
        @(negedge clk);
        frame_tick = 1'b0;
        note_valid = 1'b0;
    endtask

    task automatic frame(input bit stray);
        logic [31:0] se;
        int k;
        run_frame(stray, last_seq, last_acc);
        model_frame(se, k);
        chk("pulse_seq", last_seq, se);
        chk("accepts", last_acc, k);
        chk("score", {16'd0, score}, m_score);
        chk("streak", {24'd0, streak}, m_streak);
        chk("frame_cnt", {16'd0, frame_cnt}, m_frame);
    endtask

    task automatic press(input logic [2:0] l);
        @(negedge clk);
        btn = l;
        @(negedge clk);
        btn = 3'b000;
        m_pend |= l;
    endtask

    // e < 0 takes the expectation from the model
    task automatic query(input int x, input int y, input int e);
        int want;
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(negedge clk);
        want = (e < 0) ? int'(model_pix(x, y)) : e;
        chk($sformatf("pix(%0d,%0d)", x, y), {31'd0, pix_note}, want);
    endtask

    initial begin
        int n, j;
        model_reset();

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            note_valid = ~note_valid;
            btn        = 3'($urandom);
            frame_tick = 1'b1;
        end
        #1;
        chk("rst_ready", {31'd0, note_ready}, 0);
        chk("rst_pix", {31'd0, pix_note}, 0);
        chk("rst_hit", {31'd0, hit_pulse}, 0);
        chk("rst_miss", {31'd0, miss_pulse}, 0);
        chk("rst_score", {16'd0, score}, 0);
        chk("rst_streak", {24'd0, streak}, 0);
        frame_tick = 1'b0;
        btn        = 3'b000;
        note_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_frame_cnt", {16'd0, frame_cnt}, 0);
        chk("idle_ready", {31'd0, note_ready}, 0);
        note_valid = 1'b0;

        offer(1, 0);
        frame(1'b0);
        chk("spawn_acc", last_acc, 1);
        repeat (10) frame(1'b0);
        query(300, 45, 1);
        query(300, 56, 0);
        query(214, 45, 0);
        query(217, 40, 1);
        query(423, 55, 1);
        query(300, 39, -1);

        repeat (85) frame(1'b0);
        press(3'b010);
        frame(1'b0);
        chk("hit_seq", last_seq, 1);
        chk("hit_score", {16'd0, score}, 1);
        chk("hit_streak", {24'd0, streak}, 1);
        query(300, 390, 0);

        offer(1, 0);
        frame(1'b0);
        repeat (105) frame(1'b0);
        press(3'b010);
        frame(1'b0);
        chk("late_seq", last_seq, 2);
        chk("late_streak", {24'd0, streak}, 0);
        repeat (13) frame(1'b0);
        frame(1'b0);
        chk("expire_seq", last_seq, 2);

        repeat (9) offer(0, 0);
        frame(1'b0);
        chk("full_acc", last_acc, 8);
        frame(1'b0);
        chk("full_stall", last_acc, 0);
        repeat (94) frame(1'b0);
        press(3'b001);
        frame(1'b0);
        chk("reuse_seq", last_seq, 1);
        chk("reuse_acc", last_acc, 1);
        repeat (23) frame(1'b0);
        frame(1'b0);
        chk("burst_seq", last_seq, 32'h2AAA);
        if (pcyc.size() == 7) chk("burst_gap", pcyc[6] - pcyc[0], 6);
        else chk("burst_n", pcyc.size(), 7);

        offer(3, 0);
        frame(1'b0);
        chk("lane3_acc", last_acc, 1);
        repeat (8) offer(2, 0);
        frame(1'b0);
        chk("lane3_noslot", last_acc, 7);
        frame(1'b1);

        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_hit", {31'd0, hit_pulse}, 0);
        chk("mid_rst_miss", {31'd0, miss_pulse}, 0);
        chk("mid_rst_ready", {31'd0, note_ready}, 0);
        chk("mid_rst_score", {16'd0, score}, 0);
        chk("mid_rst_frame", {16'd0, frame_cnt}, 0);
        @(negedge clk);
        chk("mid_rst_pix", {31'd0, pix_note}, 0);
        rst = 1'b1;
        model_reset();
        query(500, 40, 0);
        query(100, 420, 0);

        offer(3, 5);
        for (int i = 0; i < 4; i++) begin
            frame(1'b0);
            chk("stall_acc", last_acc, 0);
        end
        frame(1'b0);
        chk("stall_go", last_acc, 1);
        chk("stall_frame", {16'd0, frame_cnt}, 5);
        offer(0, 0);
        offer(2, 0);
        frame(1'b0);
        chk("pair_acc", last_acc, 2);
        repeat (95) frame(1'b0);
        press(3'b111);
        frame(1'b0);
        chk("hmh_seq", last_seq, 32'h19);
        chk("hmh_score", {16'd0, score}, 2);
        chk("hmh_streak", {24'd0, streak}, 1);
        n = pcyc.size();
        chk("hmh_n", n, 3);
        if (n >= 3) chk("hmh_gap", pcyc[n-1] - pcyc[n-3], 2);

        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 1) == 1 && offq.size() < 4)
                offer($urandom_range(0, 3), m_frame + $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) press(3'($urandom));
            frame($urandom_range(0, 9) == 0);
            query($urandom_range(0, 639), $urandom_range(0, 479), -1);
            j = $urandom_range(0, 7);
            if (m_v[j])
                query(lo[m_lane[j]] + $urandom_range(0, 207), m_y[j] + $urandom_range(0, 17), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
Sequences falling notes for the three-lane playfield. Accepts timed note events, keeps a table of active notes, and advances them once per frame during vertical blank. It judges button presses against the strike window and answers per-pixel "note here?" queries for the pixel pipeline. It sits between the chart/ROM reader and the display colour mux, and runs in the pixel clock domain.

Parameters:
SLOTS, 8, number of simultaneously active notes (2..16)
SPEED, 4, pixels a note falls per frame
NOTE_H, 16, note height in pixels
HIT_Y, 380, strike-line top row
HIT_WIN, 12, half-width of the hit window in rows around HIT_Y
MISS_Y, 480, a note whose top row reaches this value has expired

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
note_valid  in  1  note event offered
note_ready  out  1  note event accepted this cycle when high with note_valid
note_lane  in  2  lane 0..2; value 3 is invalid
note_frame  in  16  frame number at which the note spawns
btn  in  3  lane buttons, synchronous level, one bit per lane
pix_x  in  10  query column (h_count)
pix_y  in  10  query row (v_count)
pix_note  out  1  queried pixel lies inside an active note; 1-cycle latency
hit_pulse  out  1  one-cycle pulse, successful hit
miss_pulse  out  1  one-cycle pulse, expired note or stray press
score  out  16  hit count, saturating at 16'hFFFF
streak  out  8  consecutive hits, saturating at 255, cleared on miss
frame_cnt  out  16  frames since reset, wraps

Behaviour:
- Reset (rst low, asynchronous): all slots invalid; FSM=IDLE; note_ready, pix_note, hit_pulse, miss_pulse = 0; score, streak, frame_cnt, btn_pend, btn_prev = 0.
- Lane geometry is fixed. Lane0 x 4..211. Lane1 x 217..423. Lane2 x 428..635.
- Slot = {valid, lane[1:0], y[9:0]}. The slot table changes only in ADVANCE, JUDGE and SPAWN.
- Button edges: btn_prev registers btn every cycle. A rising edge in a lane ORs into btn_pend[lane] in any state.
- FSM:
  - IDLE: on frame_tick, frame_cnt += 1 and go to ADVANCE with idx=0.
  - ADVANCE (SLOTS cycles, one slot per cycle): for each valid slot, y += SPEED. If the new y >= MISS_Y, clear valid and pulse miss_pulse. The pulse is one per expired slot, so back-to-back pulses are legal. Reset streak on each expiry. After idx=SLOTS-1, go to JUDGE.
  - JUDGE (SLOTS cycles): snapshot btn_pend at entry and clear btn_pend, keeping edges that arrive during JUDGE. For each lane in the snapshot, the lowest-index valid slot in that lane with |y - HIT_Y| <= HIT_WIN is cleared. That lane scores a hit: hit_pulse, score+1, streak+1. A snapshot lane with no such slot scores a miss: miss_pulse, streak=0. Emit results one lane per cycle in lane order, in the first 3 JUDGE cycles, so pulses never merge. Then go to SPAWN.
  - SPAWN: note_ready is high only in SPAWN, and only when a free slot exists and frame_cnt >= note_frame (unsigned compare). Accept at most one event per cycle. A valid lane fills the lowest free slot with y=0. Lane 3 is accepted and dropped. Stay in SPAWN while accepts continue. Return to IDLE on the first cycle with no accept, or when no free slot remains.
- frame_tick arriving outside IDLE is ignored and frame_cnt does not increment. The full sequence is at most 2*SLOTS+1+SLOTS cycles, well inside vertical blank.
- pix_note is registered. It is set when any valid slot's lane range contains pix_x and y <= pix_y < y+NOTE_H, all compares 10-bit unsigned, evaluated against the table each cycle.
- y arithmetic uses 11 bits internally so y+SPEED and y+NOTE_H never wrap.
- score and streak saturate; frame_cnt wraps 16'hFFFF -> 0.
- Reset mid-sequence aborts immediately. All state returns to reset values and no pulse is emitted.

Test Plan:
- Reset: hold rst low, toggle note_valid/btn -> note_ready=0, pix_note=0, score=0, all pulses 0; release -> FSM idle, frame_cnt=0.
- Spawn+fall: offer lane1, note_frame=0, then 10 frame_ticks -> slot y=40. pix_x=300, pix_y=45 gives pix_note=1 one cycle later; pix_y=56 gives 0; pix_x=214 gives 0.
- Hit: after spawn, 95 frames (y=380) then press btn[1] -> next JUDGE gives one hit_pulse, score=1, streak=1, slot freed. The same press at y=420 -> miss_pulse, streak=0.
- Expiry: let a note fall 120 frames untouched -> exactly one miss_pulse in ADVANCE when y reaches 480; slot reusable.
- Full table: offer 9 lane0 notes in one SPAWN -> 8 accepted, note_ready low for the 9th until a slot frees.
- Edge cases: lane=3 event accepted, no slot used. note_frame=5 stalls until frame_cnt=5. Simultaneous btn=3'b111 with notes in lanes 0 and 2 -> hit, miss, hit on consecutive cycles; score=2, streak=1.
